// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared cycle-type codes, FSM states and word geometry for the memory bus responder
package mem_bus_pkg;
  localparam logic [1:0] N_CYCLE = 2'b00;
  localparam logic [1:0] S_CYCLE = 2'b01;
  localparam logic [1:0] I_CYCLE = 2'b10;
  localparam logic [1:0] C_CYCLE = 2'b11;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: single-port word RAM with byte-lane write enables and registered read
module mem_word_array #(
  parameter int DEPTH = 200,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      q <= mem[addr];
    end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: nMREQ/SEQ memory responder with per-cycle-type wait states.
// Defining MEM_ABORT_EN adds the abort port and out-of-range access rejection.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int NUM_OF_BYTES = 800,
  parameter int N_WAIT = 2,
  parameter int S_WAIT = 0,
  parameter int WAIT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  nmreq_seq,
  input  logic [31:0] addr,
  input  logic        write_en,
  input  logic [3:0]  byte_en,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        nwait,
  output logic        done,
  output logic [31:0] read_data,
  output logic        seq_err
`ifdef MEM_ABORT_EN
  ,
  output logic        abort
`endif
);
  localparam int DEPTH = NUM_OF_BYTES / WORD_BYTES;
  localparam int AW = $clog2(DEPTH);
  state_t state;
  logic [WAIT_W-1:0] cnt, w;
  logic [29:0] lat_word, exp_word;
  logic [3:0] lat_be;
  logic [31:0] lat_wd, ram_q;
  logic lat_we, lat_serr, lat_oor, seq_valid, rd_flag, true_s, oor_now, unused_ok;
  assign unused_ok = ^addr[1:0];
  assign true_s = nmreq_seq == S_CYCLE && seq_valid && addr[31:2] == exp_word;
  assign w = true_s ? WAIT_W'(S_WAIT) : WAIT_W'(N_WAIT);
`ifdef MEM_ABORT_EN
  assign oor_now = {2'b00, addr[31:2]} >= 32'(DEPTH);
`else
  assign oor_now = 1'b0;
`endif
  assign ready = state == IDLE;
  assign nwait = state != WAIT;
  // RAM output is held between accesses, so gating it keeps read_data stable until the next access
  assign read_data = rd_flag ? ram_q : '0;
  mem_word_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .en   (state == ACCESS && !lat_oor),
    .we   (lat_we ? lat_be : 4'b0000),
    .addr (AW'({2'b00, lat_word} % 32'(DEPTH))),
    .wdata(lat_wd),
    .q    (ram_q)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      seq_err <= 1'b0;
      seq_valid <= 1'b0;
      exp_word <= '0;
      rd_flag <= 1'b0;
      lat_word <= '0;
      lat_we <= 1'b0;
      lat_be <= '0;
      lat_wd <= '0;
      lat_serr <= 1'b0;
      lat_oor <= 1'b0;
`ifdef MEM_ABORT_EN
      abort <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      seq_err <= 1'b0;
`ifdef MEM_ABORT_EN
      abort <= 1'b0;
`endif
      case (state)
        IDLE:
          if (!nmreq_seq[1]) begin
            lat_word <= addr[31:2];
            lat_we <= write_en;
            lat_be <= byte_en;
            lat_wd <= write_data;
            lat_serr <= nmreq_seq == S_CYCLE && !true_s;
            lat_oor <= oor_now;
            cnt <= w - 1'b1;
            state <= w == '0 ? ACCESS : WAIT;
          end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ACCESS;
        end
        ACCESS: begin
          done <= 1'b1;
          seq_err <= lat_serr;
`ifdef MEM_ABORT_EN
          abort <= lat_oor;
`endif
          rd_flag <= !lat_we && !lat_oor;
          exp_word <= lat_word + 1'b1;
          seq_valid <= !lat_oor;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: randomized self-checking bench against a word-array reference model
module tb_mem_bus_responder;
  import mem_bus_pkg::*;
  localparam int DEPTH = 200;
  localparam int N_W = 2;
  localparam int S_W = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] nmreq_seq = I_CYCLE;
  logic [31:0] addr = '0;
  logic write_en = 1'b0;
  logic [3:0] byte_en = '0;
  logic [31:0] write_data = '0;
  logic ready, nwait, done, seq_err;
  logic [31:0] read_data;
`ifdef MEM_ABORT_EN
  logic abort;
`endif
  int vectors = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];
  bit m_valid = 1'b0;
  logic [29:0] m_next = '0;
  logic [31:0] last_a = '0;

  always #5 clk = ~clk;

  mem_bus_responder dut (
    .clk(clk), .rst_n(rst_n), .nmreq_seq(nmreq_seq), .addr(addr),
    .write_en(write_en), .byte_en(byte_en), .write_data(write_data),
    .ready(ready), .nwait(nwait), .done(done), .read_data(read_data),
    .seq_err(seq_err)
`ifdef MEM_ABORT_EN
    , .abort(abort)
`endif
  );

  // Caller must be positioned at a negedge; returns at the negedge of the done cycle.
  task automatic access(input logic [1:0] t, input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [31:0] wd);
    bit true_s, oor;
    int w, lat, waits, idx;
    logic [31:0] exp_rd;
    vectors++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_accept: got %b want 1", ready); end
    true_s = t == S_CYCLE && m_valid && a[31:2] == m_next;
    w = true_s ? S_W : N_W;
    idx = int'(a[31:2]);
    oor = 1'b0;
`ifdef MEM_ABORT_EN
    oor = idx >= DEPTH;
`else
    idx = idx % DEPTH;
`endif
    exp_rd = (we || oor) ? 32'h0 : model_mem[idx];
    nmreq_seq = t; addr = a; write_en = we; byte_en = be; write_data = wd;
    @(posedge clk);
    #1 nmreq_seq = I_CYCLE;
    lat = 0; waits = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (nwait === 1'b0) waits++;
      if (done === 1'b1) break;
      nmreq_seq = 2'($urandom_range(0, 3)); addr = $urandom; write_en = 1'($urandom);
      byte_en = 4'($urandom); write_data = $urandom;
    end
    nmreq_seq = I_CYCLE; write_en = 1'b0;
    vectors++;
    if (lat !== w + 2) begin errors++; $display("FAIL latency a=%h: got %0d want %0d", a, lat, w + 2); end
    vectors++;
    if (waits !== w) begin errors++; $display("FAIL wait_cycles a=%h: got %0d want %0d", a, waits, w); end
    vectors++;
    if (read_data !== exp_rd) begin errors++; $display("FAIL read_data a=%h: got %h want %h", a, read_data, exp_rd); end
    vectors++;
    if (seq_err !== (t == S_CYCLE && !true_s)) begin
      errors++; $display("FAIL seq_err a=%h: got %b want %b", a, seq_err, t == S_CYCLE && !true_s);
    end
    vectors++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_on_done: got %b want 1", ready); end
`ifdef MEM_ABORT_EN
    vectors++;
    if (abort !== oor) begin errors++; $display("FAIL abort a=%h: got %b want %b", a, abort, oor); end
`endif
    if (!oor) begin
      if (we) for (int b = 0; b < 4; b++) if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      m_valid = 1'b1;
      m_next = a[31:2] + 30'd1;
    end else m_valid = 1'b0;
    last_a = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ready, nwait, done, seq_err} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: got %b want 1100", {ready, nwait, done, seq_err});
    end
    vectors++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h want 0", read_data); end
`ifdef MEM_ABORT_EN
    vectors++;
    if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort); end
`endif
    rst_n = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_idle_cycles();
    for (int i = 0; i < 4; i++) begin
      nmreq_seq = i[0] ? C_CYCLE : I_CYCLE; addr = $urandom; write_en = 1'b1; byte_en = 4'hF;
      @(negedge clk);
      vectors++;
      if ({ready, done} !== 2'b10) begin errors++; $display("FAIL idle_cycle %0d: got %b want 10", i, {ready, done}); end
    end
    nmreq_seq = I_CYCLE; write_en = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < DEPTH; i++)
      access(N_CYCLE, 32'(i * 4), 1'b1, 4'hF, i == 4 ? 32'hDEADBEEF : i == 8 ? 32'hAABBCCDD : $urandom);
  endtask

  task automatic test_n_read();
    access(N_CYCLE, 32'h10, 1'b0, 4'h0, 32'h0);
    vectors++;
    if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL n_read_0x10: got %h want deadbeef", read_data); end
  endtask

  task automatic test_byte_write();
    access(N_CYCLE, 32'h20, 1'b1, 4'b0101, 32'h11223344);
    access(N_CYCLE, 32'h20, 1'b0, 4'h0, 32'h0);
    vectors++;
    if (read_data !== 32'hAA22CC44) begin errors++; $display("FAIL byte_write_0x20: got %h want aa22cc44", read_data); end
  endtask

  task automatic test_back_to_back();
    access(N_CYCLE, 32'h40, 1'b0, 4'h0, 32'h0);
    access(S_CYCLE, 32'h44, 1'b0, 4'h0, 32'h0);
    access(S_CYCLE, 32'h48, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_seq_err();
    access(N_CYCLE, 32'h40, 1'b0, 4'h0, 32'h0);
    access(S_CYCLE, 32'h80, 1'b0, 4'h0, 32'h0);
    vectors++;
    if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_0x80: got %b want 1", seq_err); end
  endtask

  task automatic test_reset_mid();
    nmreq_seq = N_CYCLE; addr = 32'h30; write_en = 1'b1; byte_en = 4'hF; write_data = 32'h55;
    @(posedge clk);
    #1 nmreq_seq = I_CYCLE; write_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (nwait !== 1'b0) begin errors++; $display("FAIL reset_mid_in_wait: got nwait %b want 0", nwait); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({ready, nwait, done} !== 3'b110) begin errors++; $display("FAIL reset_mid_flags: got %b want 110", {ready, nwait, done}); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done: got %b want 0", done); end
    m_valid = 1'b0;
    access(N_CYCLE, 32'h30, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_range();
    access(N_CYCLE, 32'h320, 1'b0, 4'h0, 32'h0);
`ifndef MEM_ABORT_EN
    vectors++;
    if (read_data !== model_mem[0]) begin errors++; $display("FAIL wrap_0x320: got %h want %h", read_data, model_mem[0]); end
`endif
    access(N_CYCLE, 32'h400, 1'b1, 4'hF, 32'hCAFEF00D);
    access(S_CYCLE, 32'h404, 1'b0, 4'h0, 32'h0);
    access(N_CYCLE, 32'hFFFFFFFC, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic [1:0] t;
      logic [31:0] a;
      t = $urandom_range(0, 1) ? S_CYCLE : N_CYCLE;
      a = (t == S_CYCLE && $urandom_range(0, 3) != 0) ? last_a + 32'd4 : 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 31) == 0) a = 32'hFFFFFFFC;
      access(t, a, 1'($urandom), 4'($urandom), $urandom);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_cycles();
    test_preload();
    test_n_read();
    test_byte_write();
    test_back_to_back();
    test_seq_err();
    test_reset_mid();
    test_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
